serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
// PURPOSE
//  Bit-serial two's-complement subtractor: computes a - b one bit per clock, LSB first,
//  using a single 1-bit full-subtractor cell and a registered borrow.
//  Inverse of the ripple full-adder chain: same operand widths, borrow instead of carry.
//  Sits beside the adder chain in the arithmetic lab datapath; start/done handshake to a controller.
// PARAMETERS
//  WIDTH   4   operand/result width in bits (>=2)
// PORTS
//  clk         in   1      rising-edge clock
//  rst_n       in   1      asynchronous active-low reset
//  start       in   1      request: capture a/b and begin, honoured only when busy==0
//  a           in   WIDTH  minuend, sampled on accepted start
//  b           in   WIDTH  subtrahend, sampled on accepted start
//  busy        out  1      high while an operation is in RUN
//  done        out  1      one-cycle pulse: diff/borrow_out/overflow just updated
//  diff        out  WIDTH  result a-b mod 2^WIDTH, held until next completion
//  borrow_out  out  1      unsigned borrow (a < b unsigned), held with diff
//  overflow    out  1      signed overflow of a-b, held with diff
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; busy=0, done=0, diff=0, borrow_out=0, overflow=0;
//   internal shift regs, borrow flop, bit counter cleared. Reset mid-RUN aborts; no done pulse.
//  FSM: IDLE, RUN, DONE (encoding from package).
//   IDLE: start=1 -> load sh_a=a, sh_b=b, sh_d=0, bin=0, cnt=0, latch a[MSB], b[MSB]; -> RUN.
//   RUN : per cycle d=sh_a[0]^sh_b[0]^bin; bout=(~sh_a[0]&sh_b[0])|(~(sh_a[0]^sh_b[0])&bin);
//         sh_a,sh_b shift right; d enters sh_d at MSB (sh_d shifts right); bin<=bout; cnt++.
//         After cycle with cnt==WIDTH-1 -> DONE. start ignored (no effect, no queue).
//   DONE: diff<=sh_d, borrow_out<=bin, overflow<=(a_msb!=b_msb)&&(sh_d[MSB]!=a_msb);
//         done=1 this cycle only; -> IDLE, or straight to RUN if start=1 (back-to-back accepted).
//   Note: outputs registered on the DONE edge; they're visible the cycle after done asserts is NOT
//   the rule -- diff/flags are valid in the same cycle done=1 (register on RUN->DONE edge).
//  busy = (state==RUN). done asserted exactly in DONE state.
//  Latency: start sampled at edge N -> done=1 in cycle after edge N+WIDTH (WIDTH+1 edges).
//  Throughput: one result per WIDTH+1 cycles with start held high.
//  Widths: cnt is $clog2(WIDTH) bits; no arithmetic wider than 1 bit in datapath.
//  a/b changes while busy have no effect (operands captured at start).
// STRUCTURE
//  Package serial_sub_pkg: state typedef/localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
//  Sub-module full_subtractor (a, b, bin -> d, bout), purely combinational, one instance.
//  Top: FSM, three WIDTH shift registers, borrow flop, counter, output registers.
// TESTING (WIDTH=4)
//  a=7,b=3,start 1 cycle -> busy 4 cycles, done pulse; diff=4, borrow_out=0, overflow=0.
//  a=3,b=7 -> diff=4'b1100 (12), borrow_out=1, overflow=0.
//  a=4'b1000,b=1 -> diff=4'b0111, borrow_out=0, overflow=1; a=0,b=0 -> diff=0, flags 0.
//  start re-pulsed and a/b changed mid-RUN -> ignored; result still from first operands.
//  start held high across DONE (7-3 then 5-5) -> second RUN begins with no IDLE cycle; diff=4 then 0.
//  rst_n low mid-RUN -> all outputs 0 immediately, no done pulse; next start runs cleanly.
//  Exhaustive: all 256 a/b pairs vs reference model (a-b)&4'hF, borrow a<b, signed overflow.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Shared types for the bit-serial subtractor: FSM state encoding.
package serial_sub_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow out.
module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = a ^ b ^ bin;
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one full-subtractor cell and a registered borrow.
module serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out,
   output logic             overflow
);

   localparam int unsigned CW = $clog2(WIDTH);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] sh_a, sh_b, sh_d;
   logic [CW-1:0]    cnt;
   logic             bin, a_msb, b_msb;
   logic             d, bout, last, load;

   full_subtractor u_fs (
      .a    (sh_a[0]),
      .b    (sh_b[0]),
      .bin  (bin),
      .d    (d),
      .bout (bout)
   );

   assign last = (cnt == CW'(WIDTH - 1));
   assign busy = (state == ST_RUN);
   assign done = (state == ST_DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      case (state)
         ST_IDLE: if (start) begin
            state_nxt = ST_RUN;
            load      = 1'b1;
         end
         ST_RUN:  if (last) state_nxt = ST_DONE;
         ST_DONE: if (start) begin
            state_nxt = ST_RUN;
            load      = 1'b1;
         end else begin
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Results are captured on the final RUN edge using the live cell outputs,
   // so they are already valid in the cycle where done is high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_a       <= '0;
         sh_b       <= '0;
         sh_d       <= '0;
         cnt        <= '0;
         bin        <= 1'b0;
         a_msb      <= 1'b0;
         b_msb      <= 1'b0;
         diff       <= '0;
         borrow_out <= 1'b0;
         overflow   <= 1'b0;
      end else if (load) begin
         sh_a  <= a;
         sh_b  <= b;
         sh_d  <= '0;
         cnt   <= '0;
         bin   <= 1'b0;
         a_msb <= a[WIDTH-1];
         b_msb <= b[WIDTH-1];
      end else if (state == ST_RUN) begin
         sh_a <= {1'b0, sh_a[WIDTH-1:1]};
         sh_b <= {1'b0, sh_b[WIDTH-1:1]};
         sh_d <= {d, sh_d[WIDTH-1:1]};
         bin  <= bout;
         cnt  <= cnt + CW'(1);
         if (last) begin
            diff       <= {d, sh_d[WIDTH-1:1]};
            borrow_out <= bout;
            overflow   <= (a_msb ^ b_msb) & (d ^ a_msb);
         end
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor against an arithmetic reference model.
module tb_serial_subtractor;

   localparam int unsigned W = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a, b;
   logic         busy, done, borrow_out, overflow;
   logic [W-1:0] diff;

   int checks = 0;
   int errors = 0;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .a          (a),
      .b          (b),
      .busy       (busy),
      .done       (done),
      .diff       (diff),
      .borrow_out (borrow_out),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the operands.
   function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
      int ux, uy, sx, sy, r;
      logic [W-1:0] dd;
      logic bo, ov;
      ux = int'(x);
      uy = int'(y);
      sx = (ux >= 8) ? ux - 16 : ux;
      sy = (uy >= 8) ? uy - 16 : uy;
      r  = sx - sy;
      dd = W'((ux - uy + 16) % 16);
      bo = (ux < uy);
      ov = (r < -8) || (r > 7);
      return {dd, bo, ov};
   endfunction

   task automatic launch(input logic [W-1:0] ta, input logic [W-1:0] tb_v);
      @(negedge clk);
      a = ta; b = tb_v; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Waits for done from negedge n0 after the start edge; checks latency and results.
   task automatic wait_done(input logic [W-1:0] ea, input logic [W-1:0] eb, input int n0);
      int n;
      logic [W+1:0] m;
      n = n0;
      while (done !== 1'b1 && n <= int'(W) + 3) begin
         chk("busy_in_run", {31'd0, busy}, 32'd1);
         @(negedge clk);
         n++;
      end
      m = model(ea, eb);
      chk("done_seen", {31'd0, done}, 32'd1);
      chk("latency", n, W + 1);
      chk("busy_at_done", {31'd0, busy}, 32'd0);
      chk("diff", {28'd0, diff}, {28'd0, m[W+1:2]});
      chk("borrow_out", {31'd0, borrow_out}, {31'd0, m[1]});
      chk("overflow", {31'd0, overflow}, {31'd0, m[0]});
   endtask

   task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v);
      logic [W+1:0] m;
      launch(ta, tb_v);
      wait_done(ta, tb_v, 1);
      m = model(ta, tb_v);
      @(negedge clk);
      chk("done_pulse_end", {31'd0, done}, 32'd0);
      chk("diff_held", {28'd0, diff}, {28'd0, m[W+1:2]});
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
      #1;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_diff", {28'd0, diff}, 32'd0);
      chk("rst_borrow", {31'd0, borrow_out}, 32'd0);
      chk("rst_ovf", {31'd0, overflow}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      do_op(4'd7, 4'd3);
      do_op(4'd3, 4'd7);
      do_op(4'b1000, 4'd1);
      do_op(4'd0, 4'd0);

      // start re-pulsed and operands changed mid-run are ignored
      launch(4'd7, 4'd3);
      chk("busy_mid", {31'd0, busy}, 32'd1);
      @(negedge clk);
      start = 1'b1; a = 4'd0; b = 4'd15;
      @(negedge clk);
      start = 1'b0;
      wait_done(4'd7, 4'd3, 3);

      // start held across DONE: back-to-back with no idle cycle
      @(negedge clk);
      a = 4'd7; b = 4'd3; start = 1'b1;
      @(negedge clk);
      wait_done(4'd7, 4'd3, 1);
      a = 4'd5; b = 4'd5;
      @(negedge clk);
      chk("b2b_busy", {31'd0, busy}, 32'd1);
      chk("b2b_done_low", {31'd0, done}, 32'd0);
      start = 1'b0;
      wait_done(4'd5, 4'd5, 1);

      // reset mid-run aborts without a done pulse
      do_op(4'd3, 4'd7);
      launch(4'd9, 4'd2);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_diff", {28'd0, diff}, 32'd0);
      chk("abort_borrow", {31'd0, borrow_out}, 32'd0);
      chk("abort_ovf", {31'd0, overflow}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("abort_no_done", {31'd0, done}, 32'd0);
      end
      do_op(4'b1000, 4'd1);

      // exhaustive operand pairs
      for (int i = 0; i < 16; i++)
         for (int j = 0; j < 16; j++)
            do_op(W'(i), W'(j));

      // random operands with random idle gaps
      for (int k = 0; k < 40; k++) begin
         logic [W-1:0] ra, rb;
         ra = W'($urandom_range(15));
         rb = W'($urandom_range(15));
         repeat ($urandom_range(2)) @(negedge clk);
         do_op(ra, rb);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
